id_ex_stage_reg: RTL and testbench

- Pipeline register between the decode stage (control unit plus register file read) and the execute stage.
- Captures decoded control and operand fields each cycle and inserts bubbles on flush or data hazard.
- Contains the hazard detector that freezes the front end and a saturating bubble counter for performance debug.

---
 rtl/id_ex_stage_reg.sv | 207 ++++++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with hazard detection and a saturating bubble counter.
//
// Purpose:
//   Captures the decoded control and operand fields from the decode stage and
//   presents them to the execute stage one cycle later. It inserts a bubble
//   (all fields zero) on a branch flush or on a data hazard. While an external
//   freeze is active, all contents hold.
//
// Optional feature (macro FORWARDING_EN):
//   defined   : hazard only on load-use against the EX-stage instruction;
//               mem_wb_en / mem_dest are ignored.
//   undefined : hazard on any pending write-back in EX or MEM that matches a
//               source register of the decode instruction.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             branch taken in EX -> bubble next cycle (beats freeze)
//   freeze            external stall, every register and the counter hold
//   id_valid          decode stage holds a real instruction
//   pc_in .. carry_in decode-stage fields to be registered
//   src1, src2        source register indices of the decode instruction
//   two_src           decode instruction also reads src2
//   mem_wb_en         wb_en of the instruction in MEM
//   mem_dest          destination register of the instruction in MEM
//   hazard            combinational, front end holds IF/ID this cycle
//   ex_*              registered copies of the decode fields
//   bubble_count      flush/hazard bubbles inserted since reset, saturating

module id_ex_stage_reg #(
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             freeze,
    input  logic             id_valid,
    input  logic [DW-1:0]    pc_in,
    input  logic [3:0]       exec_cmd_in,
    input  logic [4:0]       ctrl_in,
    input  logic             imm_in,
    input  logic [DW-1:0]    val_rn_in,
    input  logic [DW-1:0]    val_rm_in,
    input  logic [11:0]      shift_operand_in,
    input  logic [23:0]      signed_imm24_in,
    input  logic [3:0]       dest_in,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic             carry_in,
    input  logic             mem_wb_en,
    input  logic [3:0]       mem_dest,
    output logic             hazard,
    output logic             ex_valid,
    output logic [DW-1:0]    ex_pc,
    output logic [3:0]       ex_exec_cmd,
    output logic [4:0]       ex_ctrl,
    output logic             ex_imm,
    output logic [DW-1:0]    ex_val_rn,
    output logic [DW-1:0]    ex_val_rm,
    output logic [11:0]      ex_shift_operand,
    output logic [23:0]      ex_signed_imm24,
    output logic [3:0]       ex_dest,
    output logic             ex_carry,
    output logic [CNT_W-1:0] bubble_count
);

    // Bit positions inside ctrl: {wb_en, mem_r_en, mem_w_en, status_w_en, branch_taken}
    localparam int unsigned CtrlWbEn   = 4;
    localparam int unsigned CtrlMemREn = 3;
    localparam int unsigned CtrlBranch = 0;

    logic             valid_q, valid_d;
    logic [DW-1:0]    pc_q, pc_d;
    logic [3:0]       exec_cmd_q, exec_cmd_d;
    logic [4:0]       ctrl_q, ctrl_d;
    logic             imm_q, imm_d;
    logic [DW-1:0]    val_rn_q, val_rn_d;
    logic [DW-1:0]    val_rm_q, val_rm_d;
    logic [11:0]      shift_operand_q, shift_operand_d;
    logic [23:0]      signed_imm24_q, signed_imm24_d;
    logic [3:0]       dest_q, dest_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] bubble_count_q, bubble_count_d;

    logic ex_match;
    logic raw_hazard;
    logic load_bubble;

    // ---------------------------------------------------------------------
    // Hazard detection
    // ---------------------------------------------------------------------
    assign ex_match = (src1 == dest_q) | (two_src & (src2 == dest_q));

`ifdef FORWARDING_EN
    // Forwarding covers ALU results; only a load in EX cannot be bypassed in time.
    assign raw_hazard = valid_q & ctrl_q[CtrlMemREn] & ex_match;

    logic unused_mem;
    assign unused_mem = ^{mem_wb_en, mem_dest};
`else
    logic mem_match;
    assign mem_match  = (src1 == mem_dest) | (two_src & (src2 == mem_dest));
    assign raw_hazard = (valid_q & ctrl_q[CtrlWbEn] & ex_match) | (mem_wb_en & mem_match);
`endif

    // Branches read no registers, so they never stall.
    assign hazard = ~rst & id_valid & ~ctrl_in[CtrlBranch] & raw_hazard;

    // A bubble counted by the counter: flush always, hazard only when not frozen.
    assign load_bubble = flush | (~freeze & hazard);

    // ---------------------------------------------------------------------
    // Next-state
    // ---------------------------------------------------------------------
    always_comb begin
        valid_d         = valid_q;
        pc_d            = pc_q;
        exec_cmd_d      = exec_cmd_q;
        ctrl_d          = ctrl_q;
        imm_d           = imm_q;
        val_rn_d        = val_rn_q;
        val_rm_d        = val_rm_q;
        shift_operand_d = shift_operand_q;
        signed_imm24_d  = signed_imm24_q;
        dest_d          = dest_q;
        carry_d         = carry_q;
        bubble_count_d  = bubble_count_q;

        if (load_bubble) begin
            valid_d         = 1'b0;
            pc_d            = '0;
            exec_cmd_d      = '0;
            ctrl_d          = '0;
            imm_d           = 1'b0;
            val_rn_d        = '0;
            val_rm_d        = '0;
            shift_operand_d = '0;
            signed_imm24_d  = '0;
            dest_d          = '0;
            carry_d         = 1'b0;
            if (bubble_count_q != '1) begin
                bubble_count_d = bubble_count_q + CNT_W'(1);
            end
        end else if (!freeze) begin
            valid_d         = id_valid;
            pc_d            = pc_in;
            exec_cmd_d      = exec_cmd_in;
            // An empty decode slot must not issue side effects downstream.
            ctrl_d          = id_valid ? ctrl_in : 5'b0;
            imm_d           = imm_in;
            val_rn_d        = val_rn_in;
            val_rm_d        = val_rm_in;
            shift_operand_d = shift_operand_in;
            signed_imm24_d  = signed_imm24_in;
            dest_d          = dest_in;
            carry_d         = carry_in;
        end
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q         <= 1'b0;
            pc_q            <= '0;
            exec_cmd_q      <= '0;
            ctrl_q          <= '0;
            imm_q           <= 1'b0;
            val_rn_q        <= '0;
            val_rm_q        <= '0;
            shift_operand_q <= '0;
            signed_imm24_q  <= '0;
            dest_q          <= '0;
            carry_q         <= 1'b0;
            bubble_count_q  <= '0;
        end else begin
            valid_q         <= valid_d;
            pc_q            <= pc_d;
            exec_cmd_q      <= exec_cmd_d;
            ctrl_q          <= ctrl_d;
            imm_q           <= imm_d;
            val_rn_q        <= val_rn_d;
            val_rm_q        <= val_rm_d;
            shift_operand_q <= shift_operand_d;
            signed_imm24_q  <= signed_imm24_d;
            dest_q          <= dest_d;
            carry_q         <= carry_d;
            bubble_count_q  <= bubble_count_d;
        end
    end

    assign ex_valid         = valid_q;
    assign ex_pc            = pc_q;
    assign ex_exec_cmd      = exec_cmd_q;
    assign ex_ctrl          = ctrl_q;
    assign ex_imm           = imm_q;
    assign ex_val_rn        = val_rn_q;
    assign ex_val_rm        = val_rm_q;
    assign ex_shift_operand = shift_operand_q;
    assign ex_signed_imm24  = signed_imm24_q;
    assign ex_dest          = dest_q;
    assign ex_carry         = carry_q;
    assign bubble_count     = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios plus a randomized
// run, all checked against a behavioural model of the EX-side register state.
// A second instance with a 2-bit counter exercises saturation.

module tb_id_ex_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  cmd;
        logic [4:0]  ctrl;
        logic        imm;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [11:0] sh;
        logic [23:0] s24;
        logic [3:0]  dest;
        logic        carry;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        freeze = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] pc_in = '0;
    logic [3:0]  exec_cmd_in = '0;
    logic [4:0]  ctrl_in = '0;
    logic        imm_in = 1'b0;
    logic [31:0] val_rn_in = '0;
    logic [31:0] val_rm_in = '0;
    logic [11:0] shift_operand_in = '0;
    logic [23:0] signed_imm24_in = '0;
    logic [3:0]  dest_in = '0;
    logic [3:0]  src1 = '0;
    logic [3:0]  src2 = '0;
    logic        two_src = 1'b0;
    logic        carry_in = 1'b0;
    logic        mem_wb_en = 1'b0;
    logic [3:0]  mem_dest = '0;

    logic        hazard, ex_valid, ex_imm, ex_carry;
    logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
    logic [3:0]  ex_exec_cmd, ex_dest;
    logic [4:0]  ex_ctrl;
    logic [11:0] ex_shift_operand;
    logic [23:0] ex_signed_imm24;
    logic [15:0] bubble_count;

    logic        s_hazard, s_valid, s_imm, s_carry;
    logic [31:0] s_pc, s_rn, s_rm;
    logic [3:0]  s_cmd, s_dest;
    logic [4:0]  s_ctrl;
    logic [11:0] s_sh;
    logic [23:0] s_s24;
    logic [1:0]  s_count;

    ex_t act;
    always_comb act = {ex_valid, ex_pc, ex_exec_cmd, ex_ctrl, ex_imm, ex_val_rn, ex_val_rm,
                       ex_shift_operand, ex_signed_imm24, ex_dest, ex_carry};

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DW(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .id_valid(id_valid),
        .pc_in(pc_in), .exec_cmd_in(exec_cmd_in), .ctrl_in(ctrl_in), .imm_in(imm_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .shift_operand_in(shift_operand_in),
        .signed_imm24_in(signed_imm24_in), .dest_in(dest_in), .src1(src1), .src2(src2),
        .two_src(two_src), .carry_in(carry_in), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .hazard(hazard), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_exec_cmd(ex_exec_cmd),
        .ex_ctrl(ex_ctrl), .ex_imm(ex_imm), .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm),
        .ex_shift_operand(ex_shift_operand), .ex_signed_imm24(ex_signed_imm24),
        .ex_dest(ex_dest), .ex_carry(ex_carry), .bubble_count(bubble_count)
    );

    id_ex_stage_reg #(.DW(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .id_valid(id_valid),
        .pc_in(pc_in), .exec_cmd_in(exec_cmd_in), .ctrl_in(ctrl_in), .imm_in(imm_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .shift_operand_in(shift_operand_in),
        .signed_imm24_in(signed_imm24_in), .dest_in(dest_in), .src1(src1), .src2(src2),
        .two_src(two_src), .carry_in(carry_in), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .hazard(s_hazard), .ex_valid(s_valid), .ex_pc(s_pc), .ex_exec_cmd(s_cmd),
        .ex_ctrl(s_ctrl), .ex_imm(s_imm), .ex_val_rn(s_rn), .ex_val_rm(s_rm),
        .ex_shift_operand(s_sh), .ex_signed_imm24(s_s24),
        .ex_dest(s_dest), .ex_carry(s_carry), .bubble_count(s_count)
    );

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    ex_t         m_ex = '0;
    int unsigned m_cnt = 0;
    int unsigned m_cnt2 = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic reads_reg(input logic [3:0] r);
        return (src1 == r) || (two_src && (src2 == r));
    endfunction

    function automatic logic model_hazard();
        logic h;
`ifdef FORWARDING_EN
        h = m_ex.valid && m_ex.ctrl[3] && reads_reg(m_ex.dest);
`else
        h = (m_ex.valid && m_ex.ctrl[4] && reads_reg(m_ex.dest)) ||
            (mem_wb_en && reads_reg(mem_dest));
`endif
        if (rst || !id_valid || ctrl_in[0]) h = 1'b0;
        return h;
    endfunction

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick();
        logic h;
        ex_t  nxt;
        h   = model_hazard();
        nxt = m_ex;
        if (rst) begin
            nxt = '0; m_cnt = 0; m_cnt2 = 0;
        end else if (flush || (!freeze && h)) begin
            nxt = '0;
            m_cnt  = (m_cnt  < 65535) ? m_cnt + 1 : m_cnt;
            m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
        end else if (!freeze) begin
            nxt = {id_valid, pc_in, exec_cmd_in, id_valid ? ctrl_in : 5'd0, imm_in, val_rn_in,
                   val_rm_in, shift_operand_in, signed_imm24_in, dest_in, carry_in};
        end
        @(posedge clk);
        #1;
        m_ex = nxt;
    endtask

    task automatic rand_inputs();
        id_valid         = ($urandom_range(0, 5) != 0);
        pc_in            = $urandom;
        exec_cmd_in      = 4'($urandom);
        ctrl_in          = {4'($urandom), ($urandom_range(0, 3) == 0)};
        imm_in           = 1'($urandom);
        val_rn_in        = $urandom;
        val_rm_in        = $urandom;
        shift_operand_in = 12'($urandom);
        signed_imm24_in  = 24'($urandom);
        dest_in          = 4'($urandom_range(0, 7));
        src1             = 4'($urandom_range(0, 7));
        src2             = 4'($urandom_range(0, 7));
        two_src          = 1'($urandom);
        carry_in         = 1'($urandom);
        mem_wb_en        = 1'($urandom);
        mem_dest         = 4'($urandom_range(0, 7));
    endtask

    task automatic clear_inputs();
        flush = 0; freeze = 0; id_valid = 0; pc_in = '0; exec_cmd_in = '0; ctrl_in = '0;
        imm_in = 0; val_rn_in = '0; val_rm_in = '0; shift_operand_in = '0;
        signed_imm24_in = '0; dest_in = '0; src1 = 4'd15; src2 = 4'd15; two_src = 0;
        carry_in = 0; mem_wb_en = 0; mem_dest = 4'd14;
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            flush = 1'($urandom);
            tick();
            n_checks++;
            if (act !== '0 || bubble_count !== 16'd0 || s_count !== 2'd0) begin
                $display("FAIL reset_outputs: got %h cnt %0d, want all zero", act, bubble_count);
            end else n_pass++;
            #1;
            n_checks++;
            if (hazard !== 1'b0) $display("FAIL reset_hazard: got %b, want 0", hazard);
            else n_pass++;
        end
        rst = 0;
        clear_inputs();
        id_valid = 1; exec_cmd_in = 4'b0011; ctrl_in = 5'b10000; dest_in = 4'd3;
        val_rn_in = 32'd5; pc_in = 32'h104;
        #1;
        n_checks++;
        if (hazard !== 1'b0) $display("FAIL first_load_hazard: got %b, want 0", hazard);
        else n_pass++;
        tick();
        n_checks++;
        if (ex_dest !== 4'd3 || ex_val_rn !== 32'd5 || ex_valid !== 1'b1 ||
            ex_exec_cmd !== 4'b0011 || act !== m_ex) begin
            $display("FAIL first_load: got %h, want %h", act, m_ex);
        end else n_pass++;
    endtask

    task automatic test_flush_freeze();
        rand_inputs();
        id_valid = 1;
        flush = 1; freeze = 1;
        tick();
        flush = 0; freeze = 0;
        n_checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 5'd0 || act !== '0 || bubble_count !== 16'd1) begin
            $display("FAIL flush_with_freeze: got %h cnt %0d, want 0 cnt 1", act, bubble_count);
        end else n_pass++;
    endtask

    task automatic test_freeze_hold();
        ex_t         snap;
        logic [15:0] cnt_snap;
        clear_inputs();
        rand_inputs();
        ctrl_in[0] = 1'b1;  // branch: guarantees a real load
        tick();
        snap = act;
        cnt_snap = bubble_count;
        n_checks++;
        if (act !== m_ex) $display("FAIL pre_freeze_load: got %h, want %h", act, m_ex);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            freeze = 1;
            tick();
            n_checks++;
            if (act !== snap || act !== m_ex || bubble_count !== cnt_snap) begin
                $display("FAIL freeze_hold: got %h cnt %0d, want %h cnt %0d",
                         act, bubble_count, snap, cnt_snap);
            end else n_pass++;
        end
        freeze = 0;
    endtask

`ifdef FORWARDING_EN
    task automatic test_load_use();
        clear_inputs();
        id_valid = 1; ctrl_in = 5'b11000; dest_in = 4'd4; src1 = 4'd1; src2 = 4'd2;
        tick();  // LDR R4 now in EX
        clear_inputs();
        id_valid = 1; ctrl_in = 5'b10000; exec_cmd_in = 4'b0011; dest_in = 4'd5;
        src1 = 4'd4; src2 = 4'd9; val_rn_in = 32'hAB;
        #1;
        n_checks++;
        if (hazard !== 1'b1) $display("FAIL load_use_hazard: got %b, want 1", hazard);
        else n_pass++;
        tick();
        n_checks++;
        if (ex_valid !== 1'b0 || act !== '0) $display("FAIL load_use_bubble: got %h, want 0", act);
        else n_pass++;
        #1;
        n_checks++;
        if (hazard !== 1'b0) $display("FAIL load_use_replay_hazard: got %b, want 0", hazard);
        else n_pass++;
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_dest !== 4'd5 || act !== m_ex) begin
            $display("FAIL load_use_replay: got %h, want %h", act, m_ex);
        end else n_pass++;
    endtask
`else
    task automatic test_mem_hazard();
        clear_inputs();
        tick();  // EX holds an invalid slot so only the MEM side can match
        id_valid = 1; ctrl_in = 5'b10000; mem_wb_en = 1; mem_dest = 4'd7;
        src1 = 4'd1; src2 = 4'd7; two_src = 1;
        #1;
        n_checks++;
        if (hazard !== 1'b1) $display("FAIL mem_hazard_two_src: got %b, want 1", hazard);
        else n_pass++;
        two_src = 0;
        #1;
        n_checks++;
        if (hazard !== 1'b0) $display("FAIL mem_hazard_one_src: got %b, want 0", hazard);
        else n_pass++;
        ctrl_in = 5'b10001; two_src = 1;
        #1;
        n_checks++;
        if (hazard !== 1'b0) $display("FAIL mem_hazard_branch: got %b, want 0", hazard);
        else n_pass++;
        tick();
    endtask
`endif

    task automatic test_saturation();
        int unsigned exp_seq [5];
        exp_seq = '{1, 2, 3, 3, 3};
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            rand_inputs();
            flush = 1;
            tick();
            n_checks++;
            if (s_count !== 2'(exp_seq[i]) || 32'(s_count) !== m_cnt2) begin
                $display("FAIL saturation[%0d]: got %0d, want %0d", i, s_count, exp_seq[i]);
            end else n_pass++;
        end
        flush = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            flush  = ($urandom_range(0, 7) == 0);
            freeze = ($urandom_range(0, 7) == 0);
            rst    = ($urandom_range(0, 63) == 0);
            #1;
            n_checks++;
            if (hazard !== model_hazard()) begin
                $display("FAIL rand_hazard[%0d]: got %b, want %b", i, hazard, model_hazard());
            end else n_pass++;
            tick();
            n_checks++;
            if (act !== m_ex || 32'(bubble_count) !== m_cnt || 32'(s_count) !== m_cnt2) begin
                $display("FAIL rand_regs[%0d]: got %h cnt %0d, want %h cnt %0d",
                         i, act, bubble_count, m_ex, m_cnt);
            end else n_pass++;
        end
        rst = 0; flush = 0; freeze = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_flush_freeze();
        test_freeze_hold();
`ifdef FORWARDING_EN
        test_load_use();
`else
        test_mem_hazard();
`endif
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
